semaforo_sequencer: RTL and testbench

Sequential lamp driver for a two-way intersection. Consumes the level-valued direction requests `NS`/`LO` produced by the combinational `Semaforo` decision block and turns them into safe, timed lamp outputs: minimum green, fixed yellow, all-red clearance, and guaranteed mutual exclusion. Sits between `Semaforo` and the lamp pins; `Semaforo` decides who wants the road, this block decides when each direction actually gets it.

---
 rtl/semaforo_pkg.sv | 44 ++++
 rtl/semaforo_phase_timer.sv | 32 +++
 rtl/semaforo_sequencer.sv | 139 +++++++++++++
 tb/tb_semaforo_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/semaforo_pkg.sv
// Shared phase encoding, lamp encoding and default timing for the semaforo lamp sequencer.
package semaforo_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    RED_TO_LO = 3'd2,
    LO_GREEN  = 3'd3,
    LO_YELLOW = 3'd4,
    RED_TO_NS = 3'd5,
    FLASH     = 3'd6
  } phase_e;

  typedef struct packed {
    logic green;
    logic yellow;
    logic red;
  } lamp_t;

  localparam lamp_t LAMP_GREEN  = 3'b100;
  localparam lamp_t LAMP_YELLOW = 3'b010;
  localparam lamp_t LAMP_RED    = 3'b001;
  localparam lamp_t LAMP_OFF    = 3'b000;

  localparam int DEF_GREEN_MIN      = 8;
  localparam int DEF_YELLOW_CYCLES  = 3;
  localparam int DEF_ALL_RED_CYCLES = 1;
  localparam int DEF_TIMER_W        = 8;

  // Lamp for one direction in the normal phases; any other phase is red.
  function automatic lamp_t direction_lamp(input phase_e ph, input logic is_ns);
    lamp_t lamp;
    lamp = LAMP_RED;
    case (ph)
      NS_GREEN:  lamp = is_ns ? LAMP_GREEN  : LAMP_RED;
      NS_YELLOW: lamp = is_ns ? LAMP_YELLOW : LAMP_RED;
      LO_GREEN:  lamp = is_ns ? LAMP_RED    : LAMP_GREEN;
      LO_YELLOW: lamp = is_ns ? LAMP_RED    : LAMP_YELLOW;
      default:   lamp = LAMP_RED;
    endcase
    return lamp;
  endfunction

endpackage

// File: rtl/semaforo_phase_timer.sv
// Phase timer: saturating up-counter with synchronous clear and asynchronous active-low reset.
module semaforo_phase_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clear_i,
  output logic [TIMER_W-1:0] count_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_q != {TIMER_W{1'b1}}) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/semaforo_sequencer.sv
// Timed, mutually exclusive lamp sequencer for a two-way intersection.
// Optional flashing-yellow mode is enabled with `define SEMAFORO_FLASH_EN.
module semaforo_sequencer
  import semaforo_pkg::*;
#(
  parameter int GREEN_MIN      = DEF_GREEN_MIN,
  parameter int YELLOW_CYCLES  = DEF_YELLOW_CYCLES,
  parameter int ALL_RED_CYCLES = DEF_ALL_RED_CYCLES,
  parameter int TIMER_W        = DEF_TIMER_W
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ns_req,
  input  logic       lo_req,
`ifdef SEMAFORO_FLASH_EN
  input  logic       flash,
`endif
  output logic       ns_green,
  output logic       ns_yellow,
  output logic       ns_red,
  output logic       lo_green,
  output logic       lo_yellow,
  output logic       lo_red,
  output logic [2:0] phase
);

  localparam logic [TIMER_W-1:0] GREEN_LAST  = TIMER_W'(GREEN_MIN - 1);
  localparam logic [TIMER_W-1:0] YELLOW_LAST = TIMER_W'(YELLOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RED_LAST    = TIMER_W'(ALL_RED_CYCLES - 1);

  phase_e             state_q, state_d;
  logic               ns_pend_q, ns_pend_d;
  logic               lo_pend_q, lo_pend_d;
  logic [TIMER_W-1:0] timer;
  logic               timer_clr;
  lamp_t              ns_lamp, lo_lamp;

  semaforo_phase_timer #(
    .TIMER_W(TIMER_W)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear_i(timer_clr),
    .count_o(timer)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      NS_GREEN:  if (timer >= GREEN_LAST && (lo_pend_q || lo_req)) state_d = NS_YELLOW;
      NS_YELLOW: if (timer == YELLOW_LAST) state_d = RED_TO_LO;
      RED_TO_LO: if (timer == RED_LAST) state_d = LO_GREEN;
      LO_GREEN:  if (timer >= GREEN_LAST && (ns_pend_q || ns_req)) state_d = LO_YELLOW;
      LO_YELLOW: if (timer == YELLOW_LAST) state_d = RED_TO_NS;
      RED_TO_NS: if (timer == RED_LAST) state_d = NS_GREEN;
`ifdef SEMAFORO_FLASH_EN
      FLASH:     if (!flash) state_d = RED_TO_NS;
`endif
      default:   state_d = RED_TO_NS;
    endcase
`ifdef SEMAFORO_FLASH_EN
    if (flash) state_d = FLASH;
`endif
  end

  // Clearing on entry to a green has priority: that direction is being served now.
  always_comb begin
    ns_pend_d = ns_pend_q | (ns_req & (state_q != NS_GREEN));
    lo_pend_d = lo_pend_q | (lo_req & (state_q != LO_GREEN));
    if (state_d == NS_GREEN && state_q != NS_GREEN) ns_pend_d = 1'b0;
    if (state_d == LO_GREEN && state_q != LO_GREEN) lo_pend_d = 1'b0;
`ifdef SEMAFORO_FLASH_EN
    if (state_q == FLASH && state_d != FLASH) begin
      ns_pend_d = 1'b0;
      lo_pend_d = 1'b0;
    end
`endif
  end

`ifdef SEMAFORO_FLASH_EN
  logic blink_q, blink_d;
  logic flash_wrap;

  // In FLASH the timer is reused as the blink half-period counter.
  assign flash_wrap = (state_q == FLASH) && (state_d == FLASH) && (timer == YELLOW_LAST);
  assign timer_clr  = (state_d != state_q) || flash_wrap;

  always_comb begin
    blink_d = blink_q;
    if (state_d == FLASH && state_q != FLASH) begin
      blink_d = 1'b1;
    end else if (flash_wrap) begin
      blink_d = ~blink_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blink_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
    end
  end
`else
  assign timer_clr = (state_d != state_q);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RED_TO_NS;
      ns_pend_q <= 1'b0;
      lo_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ns_pend_q <= ns_pend_d;
      lo_pend_q <= lo_pend_d;
    end
  end

  always_comb begin
    ns_lamp = direction_lamp(state_q, 1'b1);
    lo_lamp = direction_lamp(state_q, 1'b0);
`ifdef SEMAFORO_FLASH_EN
    if (state_q == FLASH) begin
      ns_lamp = blink_q ? LAMP_YELLOW : LAMP_OFF;
      lo_lamp = blink_q ? LAMP_YELLOW : LAMP_OFF;
    end
`endif
  end

  assign ns_green  = ns_lamp.green;
  assign ns_yellow = ns_lamp.yellow;
  assign ns_red    = ns_lamp.red;
  assign lo_green  = lo_lamp.green;
  assign lo_yellow = lo_lamp.yellow;
  assign lo_red    = lo_lamp.red;
  assign phase     = state_q;

endmodule

// File: tb/tb_semaforo_sequencer.sv
// Scoreboard testbench for semaforo_sequencer with default timing parameters.
module tb_semaforo_sequencer;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  logic ns_req  = 1'b0;
  logic lo_req  = 1'b0;
`ifdef SEMAFORO_FLASH_EN
  logic flash   = 1'b0;
`endif
  logic       ns_green, ns_yellow, ns_red;
  logic       lo_green, lo_yellow, lo_red;
  logic [2:0] phase;
  logic [5:0] lamps;

  typedef struct packed {
    logic [2:0] ph;
    logic [5:0] lamps;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  semaforo_sequencer dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .ns_req   (ns_req),
    .lo_req   (lo_req),
`ifdef SEMAFORO_FLASH_EN
    .flash    (flash),
`endif
    .ns_green (ns_green),
    .ns_yellow(ns_yellow),
    .ns_red   (ns_red),
    .lo_green (lo_green),
    .lo_yellow(lo_yellow),
    .lo_red   (lo_red),
    .phase    (phase)
  );

  always #5 clock = ~clock;

  assign lamps = {ns_green, ns_yellow, ns_red, lo_green, lo_yellow, lo_red};

  // Expected lamp pattern {ns g,y,r, lo g,y,r} for each normal phase.
  function automatic logic [5:0] lamps_for(input logic [2:0] ph);
    case (ph)
      3'd0:    return 6'b100_001;
      3'd1:    return 6'b010_001;
      3'd3:    return 6'b001_100;
      3'd4:    return 6'b001_010;
      default: return 6'b001_001;
    endcase
  endfunction

  task automatic push_seg(input logic [2:0] ph, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.ph    = ph;
      e.lamps = lamps_for(ph);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_period();
    push_seg(3'd0, 8); push_seg(3'd1, 3); push_seg(3'd2, 1);
    push_seg(3'd3, 8); push_seg(3'd4, 3); push_seg(3'd5, 1);
  endtask

  task automatic apply_reset(input logic ns_v, input logic lo_v);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    ns_req  = ns_v;
    lo_req  = lo_v;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if (phase !== 3'd5 || lamps !== 6'b001_001) begin
      errors++;
      $display("FAIL reset_hold: phase=%0d lamps=%b, expected phase=5 lamps=001001", phase, lamps);
    end
    @(negedge clock);
    ns_req  = 1'b0;
    lo_req  = 1'b0;
    reset_n = 1'b1;
    #1;
    checks++;
    if (phase !== 3'd5 || lamps !== 6'b001_001) begin
      errors++;
      $display("FAIL reset_release: phase=%0d lamps=%b, expected phase=5 lamps=001001", phase, lamps);
    end
    push_seg(3'd0, 100);
    while (exp_q.size() != 0) begin
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (phase !== e.ph || lamps !== e.lamps) begin
        errors++;
        $display("FAIL reset_idle_green: phase=%0d lamps=%b, expected phase=%0d lamps=%b",
                 phase, lamps, e.ph, e.lamps);
      end
    end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_lo_held();
    exp_t e;
    apply_reset(1'b0, 1'b1);
    push_seg(3'd0, 8); push_seg(3'd1, 3); push_seg(3'd2, 1); push_seg(3'd3, 10);
    while (exp_q.size() != 0) begin
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (phase !== e.ph || lamps !== e.lamps) begin
        errors++;
        $display("FAIL lo_held: phase=%0d lamps=%b, expected phase=%0d lamps=%b",
                 phase, lamps, e.ph, e.lamps);
      end
    end
    $display("test_lo_held done: checks=%0d errors=%0d", checks, errors);
  endtask

  // 1-cycle lo pulse at NS timer=2 must still switch; ns pulse while NS green must be ignored.
  task automatic test_pulse();
    exp_t e;
    int   cyc;
    apply_reset(1'b0, 1'b0);
    push_seg(3'd0, 8); push_seg(3'd1, 3); push_seg(3'd2, 1); push_seg(3'd3, 14);
    cyc = 0;
    while (exp_q.size() != 0) begin
      @(negedge clock);
      cyc++;
      e = exp_q.pop_front();
      checks++;
      if (phase !== e.ph || lamps !== e.lamps) begin
        errors++;
        $display("FAIL pulse cycle %0d: phase=%0d lamps=%b, expected phase=%0d lamps=%b",
                 cyc, phase, lamps, e.ph, e.lamps);
      end
      lo_req = (cyc == 3);
      ns_req = (cyc == 5);
    end
    $display("test_pulse done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_alternate();
    exp_t e;
    apply_reset(1'b1, 1'b1);
    repeat (3) push_period();
    while (exp_q.size() != 0) begin
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (phase !== e.ph || lamps !== e.lamps) begin
        errors++;
        $display("FAIL alternate: phase=%0d lamps=%b, expected phase=%0d lamps=%b",
                 phase, lamps, e.ph, e.lamps);
      end
      checks++;
      if ((ns_green && (lo_green || lo_yellow)) || (lo_green && ns_yellow)) begin
        errors++;
        $display("FAIL exclusion: lamps=%b, expected no green with opposite green/yellow", lamps);
      end
    end
    $display("test_alternate done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   budget;
    apply_reset(1'b1, 1'b1);
    budget = 0;
    while (phase !== 3'd4 && budget < 100) begin
      @(negedge clock);
      budget++;
    end
    checks++;
    if (phase !== 3'd4) begin
      errors++;
      $display("FAIL reach_lo_yellow: phase=%0d, expected 4 within 100 cycles", phase);
    end
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (phase !== 3'd5 || lamps !== 6'b001_001) begin
      errors++;
      $display("FAIL reset_mid: phase=%0d lamps=%b, expected phase=5 lamps=001001", phase, lamps);
    end
    @(negedge clock);
    ns_req  = 1'b0;
    lo_req  = 1'b0;
    reset_n = 1'b1;
    push_seg(3'd0, 4);
    while (exp_q.size() != 0) begin
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (phase !== e.ph || lamps !== e.lamps) begin
        errors++;
        $display("FAIL reset_mid_recover: phase=%0d lamps=%b, expected phase=%0d lamps=%b",
                 phase, lamps, e.ph, e.lamps);
      end
    end
    $display("test_reset_mid done: checks=%0d errors=%0d", checks, errors);
  endtask

`ifdef SEMAFORO_FLASH_EN
  task automatic test_flash();
    exp_t e;
    int   budget;
    logic [8:0] blink_pat;
    blink_pat = 9'b111_000_111;
    apply_reset(1'b0, 1'b1);
    budget = 0;
    while (phase !== 3'd3 && budget < 100) begin
      @(negedge clock);
      budget++;
    end
    checks++;
    if (phase !== 3'd3) begin
      errors++;
      $display("FAIL reach_lo_green: phase=%0d, expected 3 within 100 cycles", phase);
    end
    flash = 1'b1;
    for (int k = 0; k < 9; k++) begin
      e.ph    = 3'd6;
      e.lamps = blink_pat[8-k] ? 6'b010_010 : 6'b000_000;
      exp_q.push_back(e);
    end
    for (int k = 0; k < 9; k++) begin
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (phase !== e.ph || lamps !== e.lamps) begin
        errors++;
        $display("FAIL flash cycle %0d: phase=%0d lamps=%b, expected phase=%0d lamps=%b",
                 k, phase, lamps, e.ph, e.lamps);
      end
    end
    flash  = 1'b0;
    lo_req = 1'b0;
    push_seg(3'd5, 1);
    push_seg(3'd0, 12);
    while (exp_q.size() != 0) begin
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (phase !== e.ph || lamps !== e.lamps) begin
        errors++;
        $display("FAIL flash_exit: phase=%0d lamps=%b, expected phase=%0d lamps=%b",
                 phase, lamps, e.ph, e.lamps);
      end
    end
    $display("test_flash done: checks=%0d errors=%0d", checks, errors);
  endtask
`endif

  initial begin
    test_reset();
    test_lo_held();
    test_pulse();
    test_alternate();
    test_reset_mid();
`ifdef SEMAFORO_FLASH_EN
    test_flash();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
